// File: rtl/addr_dec_pkg.sv
// ----------------------------------------------------------------------------
// addr_dec_pkg
// Shared definitions for the Wishbone address decoder (wb_addr_dec_n) and its
// address-match sub-module:
//   - state_t        : decoder FSM states
//   - BASE_TIMER,
//     BASE_PWM,
//     BASE_PWM_1     : default peripheral base addresses (slaves 0, 1, 2)
//   - DEF_ADDR_MASK  : default shared compare mask (16-byte window per slave)
//   - idx_width()    : width of a slave index, never less than 1 bit
//   - cnt_width()    : width of the ACK timeout counter, never less than 1 bit
// ----------------------------------------------------------------------------
package addr_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [31:0] BASE_TIMER    = 32'h0200_1000;
  localparam logic [31:0] BASE_PWM      = 32'h0200_2000;
  localparam logic [31:0] BASE_PWM_1    = 32'h0200_3000;
  localparam logic [31:0] DEF_ADDR_MASK = 32'hFFFF_FFF0;

  // A single slave still needs a 1-bit index signal to keep the ports legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // TIMEOUT = 0 disables the timeout; keep a 1-bit counter so widths stay legal.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_addr_dec_n_if.sv
// ----------------------------------------------------------------------------
// wb_addr_dec_n_if
// Bus bundle between the CPU master / peripheral slaves and the decoder.
// Signal names are written from the decoder's point of view:
//   iADR  [AW]          master address
//   iSTB                master strobe
//   oACK                transfer-complete pulse to master
//   oERR                bus-error pulse to master
//   oDAT  [DW]          read data to master
//   oSTB  [NUM_SLV]     one-hot slave strobes
//   iACK  [NUM_SLV]     slave acknowledges
//   iDAT  [NUM_SLV*DW]  slave read data, slave i at [i*DW +: DW]
// With ADDR_DEC_ERRLOG_EN defined the bundle also carries:
//   oERR_ADR [AW]       address of the most recent bus error
//   oERR_CNT [16]       saturating bus-error count
// Modports: slave  = decoder side (used by wb_addr_dec_n)
//           master = environment side (CPU + peripherals)
// ----------------------------------------------------------------------------
interface wb_addr_dec_n_if #(
  parameter int NUM_SLV = 3,
  parameter int AW      = 32,
  parameter int DW      = 32
);

  logic [AW-1:0]         iADR;
  logic                  iSTB;
  logic                  oACK;
  logic                  oERR;
  logic [DW-1:0]         oDAT;
  logic [NUM_SLV-1:0]    oSTB;
  logic [NUM_SLV-1:0]    iACK;
  logic [NUM_SLV*DW-1:0] iDAT;
`ifdef ADDR_DEC_ERRLOG_EN
  logic [AW-1:0]         oERR_ADR;
  logic [15:0]           oERR_CNT;
`endif

  modport slave (
    input  iADR, iSTB, iACK, iDAT,
`ifdef ADDR_DEC_ERRLOG_EN
    output oERR_ADR, oERR_CNT,
`endif
    output oACK, oERR, oDAT, oSTB
  );

  modport master (
    output iADR, iSTB, iACK, iDAT,
`ifdef ADDR_DEC_ERRLOG_EN
    input  oERR_ADR, oERR_CNT,
`endif
    input  oACK, oERR, oDAT, oSTB
  );

endinterface

// File: rtl/addr_match.sv
// ----------------------------------------------------------------------------
// addr_match
// Combinational address matcher: NUM_SLV masked comparators followed by a
// lowest-index-wins priority encoder, so overlapping windows resolve to the
// lowest slave number.
// Ports:
//   i_adr      [AW]     address to decode
//   o_hit_any           at least one slave window matches
//   o_hit_idx  [IDX_W]  index of the lowest matching slave (0 when no hit)
// ----------------------------------------------------------------------------
module addr_match #(
  parameter int                    NUM_SLV   = 3,
  parameter int                    AW        = 32,
  parameter int                    IDX_W     = 2,
  parameter logic [NUM_SLV*AW-1:0] BASE_ADDR = '0,
  parameter logic [AW-1:0]         ADDR_MASK = '1
) (
  input  logic [AW-1:0]    i_adr,
  output logic             o_hit_any,
  output logic [IDX_W-1:0] o_hit_idx
);

  logic [NUM_SLV-1:0] w_hit;

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_cmp
    assign w_hit[g] = ((i_adr & ADDR_MASK) == (BASE_ADDR[g*AW +: AW] & ADDR_MASK));
  end

  // Scan from the top down so the last assignment is the lowest hit index.
  always_comb begin
    o_hit_any = 1'b0;
    o_hit_idx = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        o_hit_any = 1'b1;
        o_hit_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_addr_dec_n.sv
// ----------------------------------------------------------------------------
// wb_addr_dec_n
// N-slave Wishbone-classic address decoder and response router. A strobed
// master address is matched against per-slave base windows; the selected
// slave gets a registered strobe, and its ACK/read data are returned to the
// master one cycle later. Unmapped addresses, and slaves that stay silent for
// TIMEOUT cycles, are terminated with a one-cycle bus-error pulse.
// Ports:
//   iCLK    clock, rising edge
//   iRSTn   asynchronous active-low reset
//   bus     wb_addr_dec_n_if.slave (master request, slave strobes/acks/data,
//           master ack/err/data)
// Optional build macro ADDR_DEC_ERRLOG_EN: drives bus.oERR_ADR (address of the
// last bus error) and bus.oERR_CNT (saturating 16-bit error count).
// ----------------------------------------------------------------------------
module wb_addr_dec_n
  import addr_dec_pkg::*;
#(
  parameter int                    NUM_SLV   = 3,
  parameter int                    AW        = 32,
  parameter int                    DW        = 32,
  parameter logic [NUM_SLV*AW-1:0] BASE_ADDR = {BASE_PWM_1, BASE_PWM, BASE_TIMER},
  parameter logic [AW-1:0]         ADDR_MASK = DEF_ADDR_MASK,
  parameter int                    TIMEOUT   = 16
) (
  input  logic           iCLK,
  input  logic           iRSTn,
  wb_addr_dec_n_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_SLV);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_SLV-1:0] r_stb;
  logic               r_ack;
  logic               r_err;
  logic [DW-1:0]      r_dat;

  logic               w_hit_any;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_sel_ack;
  logic [DW-1:0]      w_sel_dat;
  logic               w_cnt_done;

  addr_match #(
    .NUM_SLV   (NUM_SLV),
    .AW        (AW),
    .IDX_W     (IDX_W),
    .BASE_ADDR (BASE_ADDR),
    .ADDR_MASK (ADDR_MASK)
  ) u_match (
    .i_adr     (bus.iADR),
    .o_hit_any (w_hit_any),
    .o_hit_idx (w_hit_idx)
  );

  // Only the latched slave is listened to; ACKs from other slaves are ignored.
  always_comb begin
    w_sel_ack = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_sel_ack = bus.iACK[i];
        w_sel_dat = bus.iDAT[i*DW +: DW];
      end
    end
  end

  assign w_cnt_done = (TIMEOUT != 0) && (r_cnt == TO_LAST);

  // Request accepted in IDLE -> strobe next cycle; slave ACK -> master ACK
  // next cycle. Branch order in WAIT encodes ACK > abort > timeout.
  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_stb   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.iSTB) begin
            if (w_hit_any) begin
              r_idx            <= w_hit_idx;
              r_cnt            <= '0;
              r_stb            <= '0;
              r_stb[w_hit_idx] <= 1'b1;
              r_state          <= WAIT;
            end else begin
              r_dat   <= '0;
              r_err   <= 1'b1;
              r_state <= ERR;
            end
          end
        end
        WAIT: begin
          if (w_sel_ack) begin
            r_dat   <= w_sel_dat;
            r_ack   <= 1'b1;
            r_stb   <= '0;
            r_state <= RESP;
          end else if (!bus.iSTB) begin
            r_stb   <= '0;
            r_state <= IDLE;
          end else if (w_cnt_done) begin
            r_stb   <= '0;
            r_dat   <= '0;
            r_err   <= 1'b1;
            r_state <= ERR;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP:    r_state <= IDLE;
        ERR:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.oSTB = r_stb;
  assign bus.oACK = r_ack;
  assign bus.oERR = r_err;
  assign bus.oDAT = r_dat;

`ifdef ADDR_DEC_ERRLOG_EN
  logic          w_enter_err;
  logic [AW-1:0] r_err_adr;
  logic [15:0]   r_err_cnt;

  // Mirrors the two FSM paths into ERR: unmapped request, or slave timeout.
  assign w_enter_err = ((r_state == IDLE) && bus.iSTB && !w_hit_any) ||
                       ((r_state == WAIT) && !w_sel_ack && bus.iSTB && w_cnt_done);

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_err_adr <= '0;
      r_err_cnt <= '0;
    end else if (w_enter_err) begin
      r_err_adr <= bus.iADR;
      if (r_err_cnt != 16'hFFFF) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign bus.oERR_ADR = r_err_adr;
  assign bus.oERR_CNT = r_err_cnt;
`endif

endmodule

// File: tb/tb_wb_addr_dec_n.sv
// ----------------------------------------------------------------------------
// tb_wb_addr_dec_n
// Directed bench for wb_addr_dec_n with the default three-slave map
// (slave0 0x0200_1000, slave1 0x0200_2000, slave2 0x0200_3000, TIMEOUT 16).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ----------------------------------------------------------------------------
module tb_wb_addr_dec_n;

  logic iCLK;
  logic iRSTn;
  int   n_vec;
  int   n_mis;

  wb_addr_dec_n_if #(.NUM_SLV(3), .AW(32), .DW(32)) bus ();

  wb_addr_dec_n #(
    .NUM_SLV (3),
    .AW      (32),
    .DW      (32),
    .TIMEOUT (16)
  ) dut (
    .iCLK  (iCLK),
    .iRSTn (iRSTn),
    .bus   (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    iRSTn      = 1'b0;
    bus.iADR   = '0;
    bus.iSTB   = 1'b0;
    bus.iACK   = '0;
    bus.iDAT   = '0;

    // Reset state
    repeat (2) @(posedge iCLK);
    #1;
    chk("rst_stb", 32'(bus.oSTB), 32'd0);
    chk("rst_ack", 32'(bus.oACK), 32'd0);
    chk("rst_err", 32'(bus.oERR), 32'd0);
    chk("rst_dat", bus.oDAT, 32'd0);
`ifdef ADDR_DEC_ERRLOG_EN
    chk("rst_eadr", bus.oERR_ADR, 32'd0);
    chk("rst_ecnt", 32'(bus.oERR_CNT), 32'd0);
`endif
    iRSTn = 1'b1;
    tick();

    // Zero-wait read from slave1
    bus.iADR = 32'h0200_2004;
    bus.iSTB = 1'b1;
    tick();
    chk("t1_stb", 32'(bus.oSTB), 32'h2);
    chk("t1_ack0", 32'(bus.oACK), 32'd0);
    bus.iACK = 3'b010;
    bus.iDAT[32 +: 32] = 32'hCAFE_0001;
    tick();
    chk("t1_ack", 32'(bus.oACK), 32'd1);
    chk("t1_dat", bus.oDAT, 32'hCAFE_0001);
    chk("t1_stb_off", 32'(bus.oSTB), 32'd0);
    bus.iSTB = 1'b0;
    bus.iACK = '0;
    tick();
    chk("t1_ack_pulse", 32'(bus.oACK), 32'd0);
    chk("t1_dat_hold", bus.oDAT, 32'hCAFE_0001);

    // Unmapped address
    bus.iADR = 32'h0200_5000;
    bus.iSTB = 1'b1;
    tick();
    chk("t2_err", 32'(bus.oERR), 32'd1);
    chk("t2_stb", 32'(bus.oSTB), 32'd0);
    chk("t2_dat", bus.oDAT, 32'd0);
    chk("t2_ack", 32'(bus.oACK), 32'd0);
`ifdef ADDR_DEC_ERRLOG_EN
    chk("t2_eadr", bus.oERR_ADR, 32'h0200_5000);
    chk("t2_ecnt", 32'(bus.oERR_CNT), 32'd1);
`endif
    bus.iSTB = 1'b0;
    tick();
    chk("t2_err_pulse", 32'(bus.oERR), 32'd0);

    // Slave0 never answers: 16 strobe cycles then a bus error
    bus.iADR = 32'h0200_1000;
    bus.iSTB = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t3_stb%0d", k), 32'(bus.oSTB), 32'h1);
      chk($sformatf("t3_err%0d", k), 32'(bus.oERR), 32'd0);
    end
    tick();
    chk("t3_err", 32'(bus.oERR), 32'd1);
    chk("t3_stb_off", 32'(bus.oSTB), 32'd0);
    chk("t3_ack", 32'(bus.oACK), 32'd0);
`ifdef ADDR_DEC_ERRLOG_EN
    chk("t3_eadr", bus.oERR_ADR, 32'h0200_1000);
    chk("t3_ecnt", 32'(bus.oERR_CNT), 32'd2);
`endif
    bus.iSTB = 1'b0;
    tick();
    chk("t3_err_pulse", 32'(bus.oERR), 32'd0);

    // Foreign ACK from slave2 ignored, slave0 ACKs on 5th wait cycle
    bus.iADR = 32'h0200_1008;
    bus.iSTB = 1'b1;
    bus.iDAT[0 +: 32]  = 32'h1234_5678;
    bus.iDAT[64 +: 32] = 32'hDEAD_BEEF;
    tick();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("t4_stb%0d", k), 32'(bus.oSTB), 32'h1);
      chk($sformatf("t4_ack%0d", k), 32'(bus.oACK), 32'd0);
      if (k == 1)      bus.iACK = 3'b100;
      else if (k == 5) bus.iACK = 3'b001;
      else             bus.iACK = 3'b000;
      tick();
    end
    chk("t4_ack", 32'(bus.oACK), 32'd1);
    chk("t4_dat", bus.oDAT, 32'h1234_5678);
    bus.iSTB = 1'b0;
    bus.iACK = '0;
    tick();
    chk("t4_ack_pulse", 32'(bus.oACK), 32'd0);

    // Asynchronous reset in the middle of a slave2 wait
    bus.iADR = 32'h0200_3000;
    bus.iSTB = 1'b1;
    tick();
    chk("t5_stb", 32'(bus.oSTB), 32'h4);
    #2;
    iRSTn = 1'b0;
    #1;
    chk("t5_rst_stb", 32'(bus.oSTB), 32'd0);
    chk("t5_rst_ack", 32'(bus.oACK), 32'd0);
    chk("t5_rst_err", 32'(bus.oERR), 32'd0);
    chk("t5_rst_dat", bus.oDAT, 32'd0);
    bus.iSTB = 1'b0;
    tick();
    iRSTn = 1'b1;
    tick();
    chk("t5_post_ack", 32'(bus.oACK), 32'd0);
    chk("t5_post_err", 32'(bus.oERR), 32'd0);
    chk("t5_post_stb", 32'(bus.oSTB), 32'd0);
    bus.iADR = 32'h0200_3000;
    bus.iSTB = 1'b1;
    tick();
    chk("t5_stb2", 32'(bus.oSTB), 32'h4);
    bus.iACK = 3'b100;
    bus.iDAT[64 +: 32] = 32'h5555_AAAA;
    tick();
    chk("t5_ack", 32'(bus.oACK), 32'd1);
    chk("t5_dat", bus.oDAT, 32'h5555_AAAA);
    bus.iSTB = 1'b0;
    bus.iACK = '0;
    tick();

    // Master abort in the 3rd wait cycle, then an immediate new request
    bus.iADR = 32'h0200_2000;
    bus.iSTB = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_stb_w3", 32'(bus.oSTB), 32'h2);
    bus.iSTB = 1'b0;
    tick();
    chk("t6_stb_off", 32'(bus.oSTB), 32'd0);
    chk("t6_ack", 32'(bus.oACK), 32'd0);
    chk("t6_err", 32'(bus.oERR), 32'd0);
    bus.iADR = 32'h0200_3004;
    bus.iSTB = 1'b1;
    tick();
    chk("t6_stb_new", 32'(bus.oSTB), 32'h4);
    chk("t6_ack_new0", 32'(bus.oACK), 32'd0);
    bus.iACK = 3'b100;
    bus.iDAT[64 +: 32] = 32'h0BAD_F00D;
    tick();
    chk("t6_ack_new", 32'(bus.oACK), 32'd1);
    chk("t6_dat_new", bus.oDAT, 32'h0BAD_F00D);
    bus.iSTB = 1'b0;
    bus.iACK = '0;
    tick();
    chk("t6_idle_err", 32'(bus.oERR), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/wb_addr_dec_n.md
Name: wb_addr_dec_n

Overview:
- Parametrised N-slave Wishbone-classic address decoder and response router for the SoC peripheral bus (Timer, PWM, PWM_1 and later peripherals).
- Matches the master address against a per-slave base address and a shared mask.
- Registers the slave strobe and muxes slave ACK and read data back to the master.
- Terminates unmapped or unresponsive accesses with a bus-error pulse, so the CPU never hangs.

Parameters:
- NUM_SLV, 3, number of slave ports (1..16).
- AW, 32, address width.
- DW, 32, data width.
- BASE_ADDR, {32'h0200_3000, 32'h0200_2000, 32'h0200_1000}, packed NUM_SLV*AW; slave i occupies slice [i*AW +: AW].
- ADDR_MASK, 32'hFFFF_FFF0, shared compare mask (16-byte window per slave).
- TIMEOUT, 16, cycles to wait for a slave ACK before a bus error; 0 disables the timeout.

Ports:
- iCLK  in  1  clock; all state changes on rising edge.
- iRSTn  in  1  asynchronous active-low reset.
- iADR  in  AW  master address.
- iSTB  in  1  master strobe (active high).
- oACK  out  1  transfer-complete pulse to master.
- oERR  out  1  bus-error pulse to master.
- oDAT  out  DW  read data to master.
- oSTB  out  NUM_SLV  one-hot slave strobes.
- iACK  in  NUM_SLV  slave acknowledges.
- iDAT  in  NUM_SLV*DW  slave read data; slave i at [i*DW +: DW].

Behaviour:
- Match: hit[i] = ((iADR & ADDR_MASK) == (BASE_ADDR[i] & ADDR_MASK)). On overlapping windows, the lowest index wins.
- FSM states:
  - IDLE: if iSTB=1 and any hit, latch the index and go to WAIT. If iSTB=1 and no hit, go to ERR. Otherwise stay.
  - WAIT: oSTB[idx]=1.
    - iACK[idx]=1: capture iDAT[idx], go to RESP.
    - iSTB=0 (master abort): go to IDLE with no ACK or ERR.
    - Timeout counter reaches TIMEOUT-1: go to ERR.
  - RESP: oACK=1 for exactly one cycle, oSTB all 0, then go to IDLE.
  - ERR: oERR=1 for exactly one cycle, oSTB all 0, oDAT=0, then go to IDLE.
- Latency:
  - Request sampled in cycle T; oSTB asserted from T+1.
  - Slave ACK in cycle S gives oACK in S+1.
  - A zero-wait slave therefore gives 2-cycle master latency.
  - Unmapped address gives oERR at T+1.
- ACKs from non-selected slaves are ignored.
- iACK[idx] and timeout terminal count in the same cycle: ACK wins, so RESP not ERR.
- Timeout counter: width $clog2(TIMEOUT+1). Cleared on entry to WAIT; increments each WAIT cycle; saturates and never wraps.
- Back-to-back: a new iSTB in the cycle after RESP or ERR is accepted normally from IDLE.
- oDAT is registered and holds its last value between transfers.
- Reset, including mid-transfer: state IDLE, counter 0, oSTB=0, oACK=0, oERR=0, oDAT=0, all immediately and asynchronously. No ACK or ERR is generated after reset release for the aborted transfer.

Optional Feature:
- Macro: ADDR_DEC_ERRLOG_EN.
- When defined, adds two ports:
  - oERR_ADR  out  AW: address of the most recent ERR, captured on entry to ERR.
  - oERR_CNT  out  16: count of ERR events, saturating at 16'hFFFF.
  - Both reset to 0.
- When undefined, both ports and their logic are absent; error signalling is unchanged.

Decomposition:
- Shared package addr_dec_pkg:
  - state typedef {IDLE, WAIT, RESP, ERR}.
  - Default base-address constants BASE_TIMER, BASE_PWM, BASE_PWM_1.
  - Default mask constant DEF_ADDR_MASK.
- Sub-module addr_match: combinational, NUM_SLV comparators plus lowest-index priority encoder; outputs hit_any and hit_idx.

Test Plan:
- iADR=32'h0200_2004, iSTB=1; slave1 ACKs on the first oSTB cycle with iDAT=32'hCAFE_0001 -> oSTB=3'b010 at T+1; oACK=1 and oDAT=32'hCAFE_0001 at T+2; oSTB=0.
- iADR=32'h0200_5000, iSTB=1 -> oERR=1 for one cycle at T+1; oSTB never asserted; errlog build shows oERR_ADR=32'h0200_5000 and oERR_CNT=1.
- iADR=32'h0200_1000; slave0 never ACKs, TIMEOUT=16 -> oSTB[0] high for 16 cycles, then oERR pulse, oACK stays 0.
- Slave0 selected; iACK[2]=1 pulsed, then iACK[0]=1 on the 5th WAIT cycle -> ACK from slave 2 ignored; oACK one cycle after iACK[0].
- iRSTn driven low during WAIT on slave2 -> oSTB, oACK, oERR, oDAT all 0 immediately; after release, the next access to 32'h0200_3000 completes normally.
- iSTB dropped in the 3rd WAIT cycle -> oSTB=0 the next cycle, no oACK or oERR; an immediately following request is decoded correctly.
